// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared FSM state type and wait-counter sizing for the MEM stage
package mem_stage_pkg;
  typedef enum logic {IDLE, WAIT} state_t;
  localparam int MAX_WAIT = 7;
  localparam int CNT_W = 3;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH_WORDS x 32 data memory, sync write (clk, we, idx, wd), async read (rd)
module dmem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] idx,
  input  logic [31:0]       wd,
  output logic [31:0]       rd
);
  logic [31:0] mem [DEPTH_WORDS];
  always_ff @(posedge clk)
    if (we) mem[idx] <= wd;
  assign rd = mem[idx];
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MIPS MEM stage with wait-state FSM; in clk rst MemRead MemWrite addr wd, out rd mem_stall misalign; optional MEM_MISALIGN_TRAP_EN
import mem_stage_pkg::*;
module mem_access_stage #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        mem_stall,
  output logic        misalign
);
  localparam int WC = WAIT_CYCLES > MAX_WAIT ? MAX_WAIT : WAIT_CYCLES;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WC > 0 ? WC - 1 : 0);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic req, fin, mis, we, unused;
  logic [31:0] arr_rd;
  assign req = MemRead | MemWrite;
  assign unused = ^{addr[31:ADDR_W+2], addr[1:0]};
`ifdef MEM_MISALIGN_TRAP_EN
  assign mis = req & (addr[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    if (state == IDLE) begin
      state_n = (req && WC != 0) ? WAIT : IDLE;
      cnt_n = CNT_INIT;
    end else begin
      state_n = (cnt == '0) ? IDLE : WAIT;
      cnt_n = (cnt == '0) ? cnt : cnt - 1'b1;
    end
  end
  assign fin = (state == WAIT) ? (cnt == '0) : (req && WC == 0);
  assign mem_stall = ~rst & ((state == IDLE) ? (req && WC != 0) : (cnt != '0));
  assign misalign = ~rst & fin & mis;
  assign we = ~rst & fin & MemWrite & ~mis;
  assign rd = (MemRead & ~MemWrite & ~mis) ? arr_rd : 32'h0;
  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS), .ADDR_W(ADDR_W)) u_mem (
    .clk(clk),
    .we(we),
    .idx(addr[ADDR_W+1:2]),
    .wd(wd),
    .rd(arr_rd)
  );
endmodule
